data_memory_ctrl: RTL and testbench

- Parametrised data memory for the CPU datapath, the successor to the fixed 128-byte asynchronous-read data memory.
- Clocked, little-endian, byte-addressed store with byte, half and word access sizes.
- Loads can be signed or unsigned; out-of-range and illegal accesses are flagged.
- Requests use a valid/ready handshake; each response comes one cycle after acceptance.

---
 rtl/data_memory_ctrl.sv | 208 ++++++++++++++++++++
 tb/tb_data_memory_ctrl.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/data_memory_ctrl.sv
// rtl/data_memory_ctrl.sv - clocked little-endian byte-addressed data memory with valid/ready requests
// Define DMEM_SPLIT_EN to make misaligned accesses legal, split over two cycles when they span rows.
module data_memory_ctrl #(
    parameter int DEPTH_BYTES = 128,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32
) (
    input  logic              CLK,
    input  logic              RST_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err
);
    localparam int ROWS  = DEPTH_BYTES / 4;
    localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W + 1)'(DEPTH_BYTES);

    if (DATA_W != 32) begin : g_bad_data_w
        $error("data_memory_ctrl: DATA_W must be 32");
    end
    if (DEPTH_BYTES < 4 || (DEPTH_BYTES & (DEPTH_BYTES - 1)) != 0) begin : g_bad_depth
        $error("data_memory_ctrl: DEPTH_BYTES must be a power of two and at least 4");
    end

    typedef enum logic [0:0] {IDLE = 1'b0, SPLIT2 = 1'b1} state_t;
    state_t state, state_nxt;

    logic [31:0] mem [ROWS];

    logic [2:0]       req_n;
    logic [ADDR_W:0]  req_end;
    logic             req_err;
    logic             req_span;

    logic [ROW_W-1:0] sv_row;
    logic [1:0]       sv_lane;
    logic [1:0]       sv_size;
    logic             sv_we;
    logic             sv_signed;
    logic [31:0]      sv_wdata;
    logic [31:0]      acc;

    logic             fire;
    logic             op_phase;
    logic             op_we;
    logic             op_signed;
    logic             op_err;
    logic             op_last;
    logic [1:0]       op_lane;
    logic [1:0]       op_size;
    logic [2:0]       op_n;
    logic [ROW_W-1:0] op_row;
    logic [31:0]      op_wdata;

    logic [1:0]       lane_k [4];
    logic [1:0]       byte_lane [4];
    logic [3:0]       lane_en;
    logic [31:0]      wr_data;
    logic [31:0]      rd_row;
    logic [31:0]      acc_nxt;
    logic [31:0]      ld_val;

    function automatic logic [2:0] size_bytes(input logic [1:0] s);
        case (s)
            2'b00:   return 3'd1;
            2'b01:   return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    assign req_n   = size_bytes(req_size);
    // Last byte address at one extra bit so a high address cannot wrap into range.
    assign req_end = {1'b0, req_addr} + {{(ADDR_W - 2){1'b0}}, req_n - 3'd1};

    always_comb begin
        req_err = (req_size == 2'b11) || (req_end >= DEPTH_LIM);
`ifndef DMEM_SPLIT_EN
        if ((req_size == 2'b01 && req_addr[0]) ||
            (req_size == 2'b10 && req_addr[1:0] != 2'b00)) begin
            req_err = 1'b1;
        end
`endif
    end

`ifdef DMEM_SPLIT_EN
    assign req_span = ({1'b0, req_addr[1:0]} + req_n) > 3'd4;
`else
    assign req_span = 1'b0;
`endif

    assign req_ready = RST_n && (state == IDLE);

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // In SPLIT2 the saved request drives the second row; otherwise the live request does.
    always_comb begin
        fire      = req_valid && req_ready;
        op_phase  = 1'b0;
        op_we     = req_we;
        op_size   = req_size;
        op_signed = req_signed;
        op_lane   = req_addr[1:0];
        op_row    = req_addr[ROW_W+1:2];
        op_wdata  = req_wdata;
        op_err    = req_err;
        op_last   = req_err || !req_span;
        state_nxt = state;
        if (state == SPLIT2) begin
            fire      = 1'b1;
            op_phase  = 1'b1;
            op_we     = sv_we;
            op_size   = sv_size;
            op_signed = sv_signed;
            op_lane   = sv_lane;
            op_row    = sv_row + ROW_W'(1);
            op_wdata  = sv_wdata;
            op_err    = 1'b0;
            op_last   = 1'b1;
            state_nxt = IDLE;
        end else if (fire && !op_last) begin
            state_nxt = SPLIT2;
        end
    end

    assign op_n   = size_bytes(op_size);
    assign rd_row = mem[op_row];

    // Lane l holds request byte k = l - lane0; lanes below lane0 belong to the next row.
    always_comb begin
        lane_en = '0;
        wr_data = '0;
        acc_nxt = '0;
        for (int l = 0; l < 4; l++) begin
            lane_k[l]    = 2'(l) - op_lane;
            byte_lane[l] = op_lane + 2'(l);
            lane_en[l]   = fire && ({1'b0, lane_k[l]} < op_n) && ((2'(l) >= op_lane) != op_phase);
            wr_data[8*l +: 8] = op_wdata[8*lane_k[l] +: 8];
        end
        for (int k = 0; k < 4; k++) begin
            if (lane_en[byte_lane[k]]) begin
                acc_nxt[8*k +: 8] = rd_row[8*byte_lane[k] +: 8];
            end else if (op_phase) begin
                acc_nxt[8*k +: 8] = acc[8*k +: 8];
            end
        end
    end

    always_comb begin
        case (op_n)
            3'd1:    ld_val = {{24{op_signed & acc_nxt[7]}}, acc_nxt[7:0]};
            3'd2:    ld_val = {{16{op_signed & acc_nxt[15]}}, acc_nxt[15:0]};
            default: ld_val = acc_nxt;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (fire && op_we && !op_err) begin
            for (int l = 0; l < 4; l++) begin
                if (lane_en[l]) begin
                    mem[op_row][8*l +: 8] <= wr_data[8*l +: 8];
                end
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            acc       <= '0;
            sv_row    <= '0;
            sv_lane   <= '0;
            sv_size   <= '0;
            sv_we     <= 1'b0;
            sv_signed <= 1'b0;
            sv_wdata  <= '0;
        end else begin
            rsp_valid <= fire && op_last;
            rsp_err   <= fire && op_last && op_err;
            rsp_rdata <= (fire && op_last && !op_we && !op_err) ? ld_val : '0;
            if (fire) begin
                acc <= acc_nxt;
            end
            if (state == IDLE && fire) begin
                sv_row    <= op_row;
                sv_lane   <= req_addr[1:0];
                sv_size   <= req_size;
                sv_we     <= req_we;
                sv_signed <= req_signed;
                sv_wdata  <= req_wdata;
            end
        end
    end
endmodule

// File: tb/tb_data_memory_ctrl.sv
// tb/tb_data_memory_ctrl.sv - directed scoreboard bench for data_memory_ctrl
module tb_data_memory_ctrl;
    logic        CLK = 1'b0;
    logic        RST_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    localparam logic [1:0] SB = 2'b00, SH = 2'b01, SW = 2'b10, SR = 2'b11;

    typedef struct {
        logic [31:0] rd;
        logic        err;
        int          cyc;
        int          id;
    } exp_t;

    exp_t sb[$];
    int n_cmp   = 0;
    int n_bad   = 0;
    int cyc     = 0;
    int next_id = 0;

    data_memory_ctrl #(.DEPTH_BYTES(128), .ADDR_W(32), .DATA_W(32)) dut (
        .CLK(CLK), .RST_n(RST_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string tag, input int id, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s#%0d observed=%h expected=%h", tag, id, obs, exp);
        end
    endtask

    function automatic logic [31:0] ld_model(input logic [31:0] d, input logic [1:0] size, input logic sgn);
        case (size)
            SB:      return sgn ? {{24{d[7]}}, d[7:0]} : {24'h0, d[7:0]};
            SH:      return sgn ? {{16{d[15]}}, d[15:0]} : {16'h0, d[15:0]};
            default: return d;
        endcase
    endfunction

    always @(negedge CLK) begin
        exp_t e;
        if (rsp_valid === 1'b1) begin
            chk("rsp_expected", -1, {31'b0, sb.size() != 0}, 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("rsp_cycle", e.id, 32'(cyc), 32'(e.cyc));
                chk("rsp_rdata", e.id, rsp_rdata, e.rd);
                chk("rsp_err", e.id, {31'b0, rsp_err}, {31'b0, e.err});
            end
        end else if (sb.size() != 0 && sb[0].cyc < cyc) begin
            e = sb.pop_front();
            chk("rsp_missing", e.id, {31'b0, rsp_valid}, 32'd1);
        end
    end

    task automatic issue(input logic we, input logic [1:0] size, input logic sgn,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] erd, input logic eerr, input int lat);
        exp_t e;
        req_valid  = 1'b1;
        req_we     = we;
        req_size   = size;
        req_signed = sgn;
        req_addr   = addr;
        req_wdata  = wdata;
        e.rd  = erd;
        e.err = eerr;
        e.cyc = cyc + lat;
        e.id  = next_id;
        next_id++;
        sb.push_back(e);
        @(negedge CLK);
        if (lat > 1) begin
            req_valid = 1'b0;
            chk("split_ready_low", e.id, {31'b0, req_ready}, 32'd0);
            @(negedge CLK);
            chk("split_ready_back", e.id, {31'b0, req_ready}, 32'd1);
        end
    endtask

    task automatic idle();
        req_valid = 1'b0;
        @(negedge CLK);
    endtask

    initial begin
        logic [31:0] d;
        logic [1:0]  sz;
        RST_n      = 1'b0;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_size   = 2'b00;
        req_signed = 1'b0;
        req_addr   = '0;
        req_wdata  = '0;
        repeat (3) @(negedge CLK);
        chk("reset_ready", 0, {31'b0, req_ready}, 32'd0);
        chk("reset_valid", 0, {31'b0, rsp_valid}, 32'd0);
        chk("reset_rdata", 0, rsp_rdata, 32'd0);
        chk("reset_err", 0, {31'b0, rsp_err}, 32'd0);
        RST_n = 1'b1;
        #1;
        chk("ready_after_reset", 0, {31'b0, req_ready}, 32'd1);

        issue(1'b1, SW, 1'b0, 32'd8, 32'hA1B2C3D4, 32'h0, 1'b0, 1);
        issue(1'b0, SW, 1'b0, 32'd8, 32'h0, 32'hA1B2C3D4, 1'b0, 1);
        issue(1'b0, SB, 1'b0, 32'd9, 32'h0, 32'h000000C3, 1'b0, 1);

        issue(1'b1, SB, 1'b0, 32'd5, 32'hFFFFFF00, 32'h0, 1'b0, 1);
        issue(1'b1, SB, 1'b0, 32'd4, 32'h12345680, 32'h0, 1'b0, 1);
        issue(1'b0, SB, 1'b1, 32'd4, 32'h0, 32'hFFFFFF80, 1'b0, 1);
        issue(1'b0, SB, 1'b0, 32'd4, 32'h0, 32'h00000080, 1'b0, 1);
        issue(1'b0, SH, 1'b1, 32'd4, 32'h0, 32'h00000080, 1'b0, 1);

        issue(1'b1, SW, 1'b0, 32'd124, 32'h55AA33CC, 32'h0, 1'b0, 1);
        issue(1'b0, SW, 1'b0, 32'd124, 32'h0, 32'h55AA33CC, 1'b0, 1);
        issue(1'b0, SW, 1'b0, 32'd125, 32'h0, 32'h0, 1'b1, 1);
        issue(1'b1, SH, 1'b0, 32'd126, 32'h0000BEEF, 32'h0, 1'b0, 1);
        issue(1'b1, SW, 1'b0, 32'd126, 32'hDEADDEAD, 32'h0, 1'b1, 1);
        issue(1'b0, SH, 1'b0, 32'd126, 32'h0, 32'h0000BEEF, 1'b0, 1);
        issue(1'b0, SW, 1'b0, 32'hFFFFFFFF, 32'h0, 32'h0, 1'b1, 1);

        issue(1'b0, SR, 1'b0, 32'd8, 32'h0, 32'h0, 1'b1, 1);
        issue(1'b1, SR, 1'b0, 32'd8, 32'hFFFFFFFF, 32'h0, 1'b1, 1);
        issue(1'b0, SW, 1'b0, 32'd8, 32'h0, 32'hA1B2C3D4, 1'b0, 1);
`ifndef DMEM_SPLIT_EN
        issue(1'b0, SH, 1'b0, 32'd3, 32'h0, 32'h0, 1'b1, 1);
        issue(1'b1, SW, 1'b0, 32'd10, 32'h99999999, 32'h0, 1'b1, 1);
        issue(1'b0, SW, 1'b0, 32'd8, 32'h0, 32'hA1B2C3D4, 1'b0, 1);
`endif
        idle();

        // Store accepted, then reset asserted while its response is in flight.
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_size  = SW;
        req_signed = 1'b0;
        req_addr  = 32'd32;
        req_wdata = 32'hCAFEF00D;
        @(posedge CLK);
        #1;
        RST_n     = 1'b0;
        req_valid = 1'b0;
        @(negedge CLK);
        chk("midreset_valid", 0, {31'b0, rsp_valid}, 32'd0);
        chk("midreset_ready", 0, {31'b0, req_ready}, 32'd0);
        chk("midreset_rdata", 0, rsp_rdata, 32'd0);
        @(negedge CLK);
        RST_n = 1'b1;
        #1;
        chk("ready_after_midreset", 0, {31'b0, req_ready}, 32'd1);
        issue(1'b0, SW, 1'b0, 32'd32, 32'h0, 32'hCAFEF00D, 1'b0, 1);
        issue(1'b0, SW, 1'b0, 32'd8, 32'h0, 32'hA1B2C3D4, 1'b0, 1);

        for (int p = 0; p < 4; p++) begin
            d  = 32'h9A8B7C6D + 32'(p) * 32'h11111111;
            sz = (p == 1) ? SH : (p == 2) ? SB : SW;
            chk("stream_ready", p, {31'b0, req_ready}, 32'd1);
            issue(1'b1, sz, 1'b0, 32'd64 + 32'(4 * p), d, 32'h0, 1'b0, 1);
            chk("stream_ready", p, {31'b0, req_ready}, 32'd1);
            issue(1'b0, sz, p[1], 32'd64 + 32'(4 * p), 32'h0, ld_model(d, sz, p[1]), 1'b0, 1);
        end
        idle();

`ifdef DMEM_SPLIT_EN
        issue(1'b1, SW, 1'b0, 32'd6, 32'h11223344, 32'h0, 1'b0, 2);
        issue(1'b0, SW, 1'b0, 32'd6, 32'h0, 32'h11223344, 1'b0, 2);
        issue(1'b0, SB, 1'b0, 32'd9, 32'h0, 32'h00000011, 1'b0, 1);
        issue(1'b1, SB, 1'b0, 32'd3, 32'h0000007F, 32'h0, 1'b0, 1);
        issue(1'b0, SH, 1'b1, 32'd3, 32'h0, 32'hFFFF807F, 1'b0, 2);
        issue(1'b0, SH, 1'b0, 32'd5, 32'h0, 32'h00004400, 1'b0, 1);
        idle();
`endif

        repeat (4) @(negedge CLK);
        chk("scoreboard_drained", 0, 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
